// File: rtl/core_demux_tracker_if.sv
// rtl/core_demux_tracker_if.sv - demux-bus signal bundle between core, tracker and the two target ports
interface core_demux_tracker_if;
   // core request channel
   logic              s_barrier_i;
   logic              s_exec_cancel_i;
   logic              s_exec_stall_i;
   logic              s_req_i;
   logic [31:0]       s_add_i;
   logic              s_we_i;
   logic [5:0]        s_atop_i;
   logic [31:0]       s_wdata_i;
   logic [3:0]        s_be_i;
   logic              s_gnt_o;
   logic              s_busy_o;
   // core response channel
   logic              s_r_gnt_i;
   logic              s_r_valid_o;
   logic [31:0]       s_r_rdata_o;
   // target side: port 0 = TCDM, port 1 = peripherals
   logic [1:0]        m_req_o;
   logic [31:0]       m_add_o;
   logic              m_we_o;
   logic [5:0]        m_atop_o;
   logic [31:0]       m_wdata_o;
   logic [3:0]        m_be_o;
   logic [1:0]        m_gnt_i;
   logic [1:0]        m_r_valid_i;
   logic [1:0][31:0]  m_r_rdata_i;
   logic [1:0]        m_r_ready_o;

   // view taken by the tracker itself
   modport slave (
      input  s_barrier_i, s_exec_cancel_i, s_exec_stall_i, s_req_i, s_add_i, s_we_i,
             s_atop_i, s_wdata_i, s_be_i, s_r_gnt_i, m_gnt_i, m_r_valid_i, m_r_rdata_i,
      output s_gnt_o, s_busy_o, s_r_valid_o, s_r_rdata_o, m_req_o, m_add_o, m_we_o,
             m_atop_o, m_wdata_o, m_be_o, m_r_ready_o
   );

   // view taken by the surrounding core and targets
   modport master (
      output s_barrier_i, s_exec_cancel_i, s_exec_stall_i, s_req_i, s_add_i, s_we_i,
             s_atop_i, s_wdata_i, s_be_i, s_r_gnt_i, m_gnt_i, m_r_valid_i, m_r_rdata_i,
      input  s_gnt_o, s_busy_o, s_r_valid_o, s_r_rdata_o, m_req_o, m_add_o, m_we_o,
             m_atop_o, m_wdata_o, m_be_o, m_r_ready_o
   );
endinterface

// File: rtl/core_demux_tracker.sv
// rtl/core_demux_tracker.sv - two-way address demux with in-order outstanding-response tracking
module core_demux_tracker #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [31:0] PERIPH_BASE     = 32'h1A10_0000,
   parameter logic [31:0] PERIPH_MASK     = 32'hFFF0_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   core_demux_tracker_if.slave  bus
);

   localparam int unsigned       PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned       CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   // route FIFO: one bit per in-flight transaction naming the port it went to
   logic [MAX_OUTSTANDING-1:0]   route_q;
   logic [PTR_W-1:0]             wr_ptr_q;
   logic [PTR_W-1:0]             rd_ptr_q;
   logic [CNT_W-1:0]             cnt_q;

   logic                         full;
   logic                         empty;
   logic                         sel;
   logic                         head;
   logic                         issue_ok;
   logic                         push;
   logic                         pop;

   logic                         gnt;
   logic [1:0]                   m_req;
   logic                         r_valid;
   logic [31:0]                  r_rdata;
   logic [1:0]                   m_r_ready;

   // flags, address decode and issue qualification; full/empty come from registered state only
   always_comb begin
      full     = (cnt_q == CNT_MAX);
      empty    = (cnt_q == '0);
      sel      = ((bus.s_add_i & PERIPH_MASK) == PERIPH_BASE);
      head     = route_q[rd_ptr_q];
      issue_ok = ~rst_i & bus.s_req_i & ~bus.s_exec_stall_i & ~bus.s_exec_cancel_i
                 & ~full & (~bus.s_barrier_i | empty);
   end

   // forward the request to the decoded port only; grant is a zero-cycle pass-through
   always_comb begin
      m_req      = '0;
      m_req[sel] = issue_ok;
      gnt        = issue_ok & bus.m_gnt_i[sel];
   end

   // responses are taken from the port at the FIFO head only; the other port is stalled
   always_comb begin
      r_valid   = 1'b0;
      r_rdata   = '0;
      m_r_ready = '0;
      if (~rst_i & ~empty) begin
         r_valid         = bus.m_r_valid_i[head];
         r_rdata         = bus.m_r_rdata_i[head];
         m_r_ready[head] = bus.s_r_gnt_i;
      end
   end

   assign push = gnt;
   assign pop  = r_valid & bus.s_r_gnt_i;

   assign bus.s_gnt_o     = gnt;
   assign bus.s_busy_o    = ~rst_i & ~empty;
   assign bus.s_r_valid_o = r_valid;
   assign bus.s_r_rdata_o = r_rdata;
   assign bus.m_req_o     = m_req;
   assign bus.m_r_ready_o = m_r_ready;

   // request payload is broadcast; only m_req_o qualifies which port takes it
   assign bus.m_add_o   = bus.s_add_i;
   assign bus.m_we_o    = bus.s_we_i;
   assign bus.m_atop_o  = bus.s_atop_i;
   assign bus.m_wdata_o = bus.s_wdata_i;
   assign bus.m_be_o    = bus.s_be_i;

   // route FIFO pointers and occupancy; reset discards every in-flight entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         route_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            route_q[wr_ptr_q] <= sel;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_core_demux_tracker.sv
// tb/tb_core_demux_tracker.sv - self-checking bench for core_demux_tracker
module tb_core_demux_tracker;

   localparam int          MAX   = 4;
   localparam logic [31:0] P_LO  = 32'h1A10_0000;
   localparam logic [31:0] P_HI  = 32'h1A1F_FFFF;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   core_demux_tracker_if bus ();

   core_demux_tracker #(
      .MAX_OUTSTANDING (MAX),
      .PERIPH_BASE     (32'h1A10_0000),
      .PERIPH_MASK     (32'hFFF0_0000)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference model: queue of port numbers of in-flight transactions, oldest first
   bit          route_q[$];
   logic        exp_gnt, exp_busy, exp_rvalid;
   logic [1:0]  exp_mreq, exp_mready;
   logic [31:0] exp_rdata;
   bit          m_push, m_pop, m_sel;

   typedef struct {
      logic        req;
      logic [31:0] add;
      logic        barrier;
      logic        stall;
      logic        cancel;
      logic [1:0]  m_gnt;
      logic        exp_gnt;
      logic [1:0]  exp_mreq;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      int  n;
      bit  is_periph;
      bit  may_issue;
      bit  h;
      n         = route_q.size();
      is_periph = (bus.s_add_i >= P_LO) && (bus.s_add_i <= P_HI);
      exp_gnt = 0; exp_busy = 0; exp_rvalid = 0;
      exp_mreq = 2'b00; exp_mready = 2'b00; exp_rdata = 32'h0;
      if (!rst) begin
         may_issue = bus.s_req_i && !bus.s_exec_stall_i && !bus.s_exec_cancel_i &&
                     (n < MAX) && (!bus.s_barrier_i || n == 0);
         if (may_issue) begin
            exp_mreq = is_periph ? 2'b10 : 2'b01;
            exp_gnt  = bus.m_gnt_i[is_periph];
         end
         exp_busy = (n != 0);
         if (n != 0) begin
            h          = route_q[0];
            exp_rvalid = bus.m_r_valid_i[h];
            exp_rdata  = bus.m_r_rdata_i[h];
            exp_mready = bus.s_r_gnt_i ? (h ? 2'b10 : 2'b01) : 2'b00;
         end
      end
      m_push = exp_gnt;
      m_pop  = exp_rvalid && bus.s_r_gnt_i;
      m_sel  = is_periph;
   endtask

   task automatic check_all();
      model_eval();
      chk("gnt",     bus.s_gnt_o,     exp_gnt);
      chk("m_req",   bus.m_req_o,     exp_mreq);
      chk("busy",    bus.s_busy_o,    exp_busy);
      chk("r_valid", bus.s_r_valid_o, exp_rvalid);
      chk("r_rdata", bus.s_r_rdata_o, exp_rdata);
      chk("r_ready", bus.m_r_ready_o, exp_mready);
      chk("m_add",   bus.m_add_o,     bus.s_add_i);
   endtask

   task automatic look();
      #2;
      check_all();
   endtask

   task automatic clk_edge();
      @(posedge clk);
      if (rst) route_q.delete();
      else begin
         if (m_pop) void'(route_q.pop_front());
         if (m_push) route_q.push_back(m_sel);
      end
      #1;
   endtask

   task automatic cycle();
      look();
      clk_edge();
   endtask

   task automatic idle_inputs();
      bus.s_req_i = 0; bus.s_barrier_i = 0; bus.s_exec_stall_i = 0; bus.s_exec_cancel_i = 0;
      bus.s_add_i = 32'h0; bus.s_we_i = 0; bus.s_atop_i = 6'h0; bus.s_wdata_i = 32'h0;
      bus.s_be_i = 4'hF; bus.s_r_gnt_i = 0; bus.m_gnt_i = 2'b00; bus.m_r_valid_i = 2'b00;
      bus.m_r_rdata_i[0] = 32'h0; bus.m_r_rdata_i[1] = 32'h0;
   endtask

   task automatic rand_inputs();
      int k;
      rst = ($urandom_range(0, 99) == 0);
      bus.s_req_i         = $urandom_range(0, 3) != 0;
      bus.s_barrier_i     = $urandom_range(0, 7) == 0;
      bus.s_exec_stall_i  = $urandom_range(0, 7) == 0;
      bus.s_exec_cancel_i = $urandom_range(0, 7) == 0;
      k = $urandom_range(0, 3);
      case (k)
         0:       bus.s_add_i = $urandom;
         1:       bus.s_add_i = P_LO | ($urandom & 32'h000F_FFFF);
         2:       bus.s_add_i = 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
         default: bus.s_add_i = 32'h1A20_0000 | ($urandom & 32'h000F_FFFF);
      endcase
      bus.s_we_i         = $urandom_range(0, 1);
      bus.s_atop_i       = 6'($urandom);
      bus.s_wdata_i      = $urandom;
      bus.s_be_i         = 4'($urandom);
      bus.s_r_gnt_i      = $urandom_range(0, 3) != 0;
      bus.m_gnt_i        = 2'($urandom);
      bus.m_r_valid_i    = 2'($urandom);
      bus.m_r_rdata_i[0] = $urandom;
      bus.m_r_rdata_i[1] = $urandom;
   endtask

   initial begin
      //          req add            bar stl can mgnt   gnt mreq
      vecs[0]  = '{1, 32'h1000_0000, 0, 0, 0, 2'b11, 1, 2'b01};
      vecs[1]  = '{1, 32'h1A10_0004, 0, 0, 0, 2'b11, 1, 2'b10};
      vecs[2]  = '{1, 32'h1A1F_FFFC, 0, 0, 0, 2'b11, 1, 2'b10};
      vecs[3]  = '{1, 32'h1A20_0000, 0, 0, 0, 2'b11, 1, 2'b01};
      vecs[4]  = '{1, 32'h1A10_0000, 0, 0, 0, 2'b01, 0, 2'b10};
      vecs[5]  = '{1, 32'h1000_0000, 0, 0, 0, 2'b10, 0, 2'b01};
      vecs[6]  = '{1, 32'h1000_0000, 0, 1, 0, 2'b11, 0, 2'b00};
      vecs[7]  = '{1, 32'h1A10_0000, 0, 0, 1, 2'b11, 0, 2'b00};
      vecs[8]  = '{1, 32'h1000_0000, 1, 0, 0, 2'b11, 1, 2'b01};
      vecs[9]  = '{0, 32'h1A10_0000, 0, 0, 0, 2'b11, 0, 2'b00};
      vecs[10] = '{1, 32'h0A10_0000, 0, 0, 0, 2'b11, 1, 2'b01};

      rst = 1;
      idle_inputs();
      @(posedge clk);
      #1;

      // reset then idle: request held high is ignored
      bus.s_req_i = 1; bus.s_add_i = 32'h1000_0000; bus.m_gnt_i = 2'b11;
      repeat (2) begin
         look();
         chk("rst_gnt", bus.s_gnt_o, 1'b0);
         chk("rst_mreq", bus.m_req_o, 2'b00);
         chk("rst_busy", bus.s_busy_o, 1'b0);
         clk_edge();
      end
      rst = 0; bus.s_req_i = 0;
      look();
      chk("post_rst_busy", bus.s_busy_o, 1'b0);
      clk_edge();

      // decode / gating table, evaluated combinationally from an empty tracker
      for (int i = 0; i < 11; i++) begin
         bus.s_req_i = vecs[i].req; bus.s_add_i = vecs[i].add;
         bus.s_barrier_i = vecs[i].barrier; bus.s_exec_stall_i = vecs[i].stall;
         bus.s_exec_cancel_i = vecs[i].cancel; bus.m_gnt_i = vecs[i].m_gnt;
         #2;
         chk($sformatf("vec%0d_gnt", i), bus.s_gnt_o, vecs[i].exp_gnt);
         chk($sformatf("vec%0d_mreq", i), bus.m_req_o, vecs[i].exp_mreq);
         chk($sformatf("vec%0d_busy", i), bus.s_busy_o, 1'b0);
         bus.s_req_i = 0;
         look();
         clk_edge();
      end
      idle_inputs();

      // decode and order: port 1 answers first but is held behind port 0
      bus.m_gnt_i = 2'b11; bus.s_req_i = 1; bus.s_we_i = 1; bus.s_add_i = 32'h1000_0000;
      look(); chk("t2_gnt_p0", bus.s_gnt_o, 1'b1); clk_edge();
      bus.s_we_i = 0; bus.s_add_i = 32'h1A10_0004;
      look(); chk("t2_gnt_p1", bus.s_gnt_o, 1'b1); chk("t2_mreq_p1", bus.m_req_o, 2'b10); clk_edge();
      bus.s_req_i = 0; bus.s_r_gnt_i = 1;
      bus.m_r_valid_i = 2'b10; bus.m_r_rdata_i[1] = 32'hBEEF;
      look(); chk("t2_hold_valid", bus.s_r_valid_o, 1'b0); chk("t2_hold_ready", bus.m_r_ready_o, 2'b01); clk_edge();
      bus.m_r_valid_i = 2'b11; bus.m_r_rdata_i[0] = 32'h1234;
      look(); chk("t2_first", bus.s_r_rdata_o, 32'h1234); chk("t2_first_v", bus.s_r_valid_o, 1'b1); clk_edge();
      bus.m_r_valid_i = 2'b10;
      look(); chk("t2_second", bus.s_r_rdata_o, 32'hBEEF); chk("t2_second_v", bus.s_r_valid_o, 1'b1); clk_edge();
      idle_inputs();
      look(); chk("t2_idle_busy", bus.s_busy_o, 1'b0); clk_edge();

      // full: the fifth request waits; a same-cycle pop does not free a slot
      bus.m_gnt_i = 2'b01; bus.s_req_i = 1; bus.s_add_i = 32'h1000_0040;
      repeat (4) begin look(); chk("t3_fill_gnt", bus.s_gnt_o, 1'b1); clk_edge(); end
      look(); chk("t3_full_gnt", bus.s_gnt_o, 1'b0); chk("t3_full_mreq", bus.m_req_o, 2'b00); clk_edge();
      bus.m_r_valid_i = 2'b01; bus.s_r_gnt_i = 1;
      look(); chk("t3_pop_gnt", bus.s_gnt_o, 1'b0); chk("t3_pop_valid", bus.s_r_valid_o, 1'b1); clk_edge();
      bus.m_r_valid_i = 2'b00;
      look(); chk("t3_after_pop_gnt", bus.s_gnt_o, 1'b1); clk_edge();
      bus.s_req_i = 0; bus.m_r_valid_i = 2'b01;
      repeat (4) cycle();
      idle_inputs();
      look(); chk("t3_drained_busy", bus.s_busy_o, 1'b0); clk_edge();

      // barrier: held until the first cycle the tracker is already empty
      bus.m_gnt_i = 2'b01; bus.s_req_i = 1; bus.s_add_i = 32'h1000_0100;
      repeat (2) cycle();
      bus.s_barrier_i = 1;
      look(); chk("t4_bar_gnt2", bus.s_gnt_o, 1'b0); clk_edge();
      bus.m_r_valid_i = 2'b01; bus.s_r_gnt_i = 1;
      look(); chk("t4_bar_gnt1", bus.s_gnt_o, 1'b0); clk_edge();
      look(); chk("t4_bar_popcyc", bus.s_gnt_o, 1'b0); clk_edge();
      bus.m_r_valid_i = 2'b00;
      look(); chk("t4_bar_release", bus.s_gnt_o, 1'b1); clk_edge();
      bus.s_req_i = 0; bus.s_barrier_i = 0; bus.m_r_valid_i = 2'b01;
      cycle();
      idle_inputs();
      cycle();

      // stall then cancel: nothing forwarded, outstanding count untouched
      bus.m_gnt_i = 2'b01; bus.s_req_i = 1; bus.s_add_i = 32'h1000_0200;
      cycle();
      bus.s_exec_stall_i = 1;
      repeat (3) begin
         look(); chk("t5_stall_mreq", bus.m_req_o, 2'b00); chk("t5_stall_gnt", bus.s_gnt_o, 1'b0);
         chk("t5_stall_busy", bus.s_busy_o, 1'b1); clk_edge();
      end
      bus.s_exec_stall_i = 0; bus.s_exec_cancel_i = 1;
      look(); chk("t5_cancel_mreq", bus.m_req_o, 2'b00); chk("t5_cancel_gnt", bus.s_gnt_o, 1'b0); clk_edge();
      bus.s_exec_cancel_i = 0; bus.s_req_i = 0; bus.m_r_valid_i = 2'b01; bus.s_r_gnt_i = 1;
      look(); chk("t5_one_left", bus.s_r_valid_o, 1'b1); clk_edge();
      idle_inputs();
      look(); chk("t5_empty", bus.s_busy_o, 1'b0); clk_edge();

      // response backpressure on the peripheral port
      bus.m_gnt_i = 2'b10; bus.s_req_i = 1; bus.s_add_i = 32'h1A10_0008;
      cycle();
      bus.s_req_i = 0; bus.m_r_valid_i = 2'b10; bus.m_r_rdata_i[1] = 32'hCAFE_F00D;
      repeat (2) begin
         look(); chk("t6_bp_ready", bus.m_r_ready_o, 2'b00); chk("t6_bp_valid", bus.s_r_valid_o, 1'b1);
         chk("t6_bp_data", bus.s_r_rdata_o, 32'hCAFE_F00D); chk("t6_bp_busy", bus.s_busy_o, 1'b1); clk_edge();
      end
      bus.s_r_gnt_i = 1;
      look(); chk("t6_pop_ready", bus.m_r_ready_o, 2'b10); chk("t6_pop_busy", bus.s_busy_o, 1'b1); clk_edge();
      idle_inputs();
      look(); chk("t6_busy_off", bus.s_busy_o, 1'b0); chk("t6_rdata_zero", bus.s_r_rdata_o, 32'h0); clk_edge();

      // randomized traffic, including occasional mid-flight resets
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         cycle();
      end
      rst = 0;
      idle_inputs();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
